// File: rtl/demux_stream.sv
// demux_stream: one-hot 1-to-N stream demux with a 1-entry registered slot per output;
// beats with a non-one-hot select are accepted, dropped, flagged and counted.
module demux_stream #(
  parameter int DATA_W = 4,
  parameter int N_OUT  = 4,
  parameter int CNT_W  = 8
)(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_W-1:0]       in_data_i,
  input  logic [N_OUT-1:0]        in_sel_i,
  output logic [N_OUT-1:0]        out_valid_o,
  input  logic [N_OUT-1:0]        out_ready_i,
  output logic [N_OUT*DATA_W-1:0] out_data_o,
  output logic                    err_o,
  output logic [CNT_W-1:0]        drop_cnt_o,
  input  logic                    err_clr_i
);
  localparam logic [N_OUT-1:0] ONE = {{(N_OUT-1){1'b0}}, 1'b1};
  logic [N_OUT-1:0]        r_valid;
  logic [N_OUT*DATA_W-1:0] r_data;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;
  logic                    w_legal, w_ready_leg, w_acc, w_drop;
  logic [N_OUT-1:0]        w_load;
  assign w_legal     = (in_sel_i != '0) && ((in_sel_i & (in_sel_i - ONE)) == '0);
  // a slot can take a beat when empty or being drained in the same cycle
  assign w_ready_leg = |(in_sel_i & (~r_valid | out_ready_i));
  assign in_ready_o  = w_legal ? w_ready_leg : 1'b1;
  assign w_acc       = in_valid_i & in_ready_o;
  assign w_drop      = w_acc & ~w_legal;
  assign w_load      = (w_acc & w_legal) ? in_sel_i : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_load | (r_valid & ~out_ready_i);
      for (int k = 0; k < N_OUT; k++)
        if (w_load[k]) r_data[k*DATA_W +: DATA_W] <= in_data_i;
    end
  end
  // a drop in the same cycle as a clear wins, restarting the count at one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_drop) begin
      r_err <= 1'b1;
      r_cnt <= err_clr_i ? {{(CNT_W-1){1'b0}}, 1'b1} : (&r_cnt ? r_cnt : r_cnt + 1'b1);
    end else if (err_clr_i) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end
  end
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign err_o       = r_err;
  assign drop_cnt_o  = r_cnt;
endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- 1-to-N stream demultiplexer with one-hot select, and the distributing counterpart of the team's one-hot N-to-1 mux.
- Each input beat is routed, under valid/ready handshake, into a 1-entry registered slot on the output selected by the one-hot select.
- Beats carrying an illegal (non-one-hot) select are accepted and dropped, counted and flagged.
- Sits between a single producer and N independent consumers.

Parameters:
DATA_W, 4, width of one data beat
N_OUT, 4, number of output channels (>=2)
CNT_W, 8, width of drop counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  reset, asynchronous, active-low
in_valid_i  input  1  input beat valid
in_ready_o  output  1  input beat accepted when in_valid_i & in_ready_o
in_data_i  input  DATA_W  input beat data
in_sel_i  input  N_OUT  one-hot destination select, sampled with in_data_i
out_valid_o  output  N_OUT  per-channel slot valid
out_ready_i  input  N_OUT  per-channel consumer ready
out_data_o  output  N_OUT*DATA_W  channel k data at bits [k*DATA_W +: DATA_W]
err_o  output  1  sticky: an illegal-select beat was dropped
drop_cnt_o  output  CNT_W  count of dropped beats, saturating
err_clr_i  input  1  synchronous clear of err_o and drop_cnt_o

Behaviour:
- Reset (rst_ni low, asynchronous):
  - out_valid_o=0, out_data_o=0, err_o=0, drop_cnt_o=0.
  - Holds while low; release takes effect at the next clock edge.
- Reset mid-transfer discards all slot contents. No beat survives reset.
- Legal select means exactly one bit of in_sel_i is set (popcount==1). Everything else, including all-zero, is illegal.
- in_ready_o is combinational:
  - Legal select to channel k: in_ready_o = ~out_valid_o[k] | out_ready_i[k].
  - Illegal select: in_ready_o = 1.
- Producer rule: in_data_i and in_sel_i stay stable while in_valid_i=1 and the beat is not accepted. The bench checks this; the block does not enforce it.
- Channel k drain: out_valid_o[k] & out_ready_i[k] at a rising edge consumes the slot.
- Channel k load: legal accept to k at a rising edge writes in_data_i to slot k and sets out_valid_o[k]=1.
- Latency: a beat accepted at edge n is visible on out_valid_o/out_data_o immediately after edge n. There is no combinational in-to-out path.
- Same-cycle load and drain on channel k: the new beat replaces the old one and out_valid_o[k] stays 1. This gives full throughput of 1 beat/cycle per channel.
- Drain without load: out_valid_o[k] goes to 0 and out_data_o slice k holds its last value.
- Channels are independent. A full, stalled channel never blocks beats to other channels once the producer changes select, which it may do only after acceptance.
- Illegal accept (in_valid_i=1 with illegal select):
  - The beat is discarded and no slot changes.
  - err_o is set to 1.
  - drop_cnt_o increments, saturating at 2^CNT_W-1.
- err_clr_i=1 at an edge clears err_o and drop_cnt_o.
- err_clr_i in the same cycle as an illegal accept: the accept wins, giving err_o=1 and drop_cnt_o=1.
- in_valid_i=0: no state change apart from drains; in_sel_i is ignored.

Test Plan:
1. Reset and basic routing: rst_ni low mid-stream with out_valid_o=0101 -> all outputs and counters 0 immediately, before the next edge. After release, with all out_ready_i=1, send data 4'hA to sel 0001, 4'h5 to 0010, 4'hC to 0100, 4'h3 to 1000 -> each appears on its slice one cycle after acceptance, and out_valid_o is one-hot per cycle.
2. Backpressure: out_ready_i[2]=0, send 4'h7 then 4'h9 to sel 0100 -> the first beat is accepted and in_ready_o=0 for the second. Raise out_ready_i[2] -> 4'h7 drains, 4'h9 is accepted the same cycle, and out_valid_o[2] stays 1.
3. Independence: channel 1 full and stalled, then send 4'hE to sel 1000 -> accepted immediately, appears on channel 3, and channel 1 data is unchanged.
4. Illegal select: send sel 0000, 0011 and 1111 with valid -> in_ready_o=1 for each, no out_valid_o change, err_o=1, drop_cnt_o=3.
5. Clear and simultaneous events: err_clr_i=1 alone -> err_o=0, drop_cnt_o=0. err_clr_i=1 together with an illegal beat -> err_o=1, drop_cnt_o=1. Send 260 illegal beats -> drop_cnt_o saturates at 255.
6. Random soak: 1000 cycles of random one-hot/illegal selects, random data and random out_ready_i -> a scoreboard shows every legal accepted beat delivered once, in order per channel, with none lost or duplicated.
